// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer state type and helpers shared by the ALU
// front-end and the ALU benches.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOTA = 4'd6;
  localparam logic [3:0] OP_NOTB = 4'd7;
  localparam logic [3:0] OP_SQA  = 4'd8;
  localparam logic [3:0] OP_SQB  = 4'd9;
  localparam logic [3:0] OP_LT   = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_LAST = 4'd12;

  // Width of one result FIFO entry: {err, data}
  localparam int RES_W = 9;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_OPND = 2'd1,
    S_EXEC = 2'd2
  } seq_state_t;

  // Opcodes above OP_LAST have no defined ALU behaviour
  function automatic logic op_is_undefined(input logic [3:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: single-clock FIFO with combinational head read from
// registered storage. DEPTH must be a power of two (>= 2) so that the
// pointers wrap naturally. A push while full is dropped even if a pop
// happens in the same cycle; the caller is expected to check full first.
module alu_result_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Head shows zero when empty so stale storage never leaks out after reset
  assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: decodes two-byte commands (header opcode, then A/B
// operand byte), drives registered operands into the 4-bit ALU and queues
// {err, result} into a result FIFO. Opcodes above OP_LAST are reported as
// errors with zero data.
// Optional build macro ALU_SEQ_DIVZERO_GUARD_EN: divide by zero pushes
// data 8'hFF with err set instead of the raw ALU value.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_result,
  output logic [7:0] out_data,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [3:0]       hdr_op_reg;
  logic [3:0]       alu_op_reg;
  logic [3:0]       alu_a_reg;
  logic [3:0]       alu_b_reg;
  logic             in_fire;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RES_W-1:0] push_word;
  logic [RES_W-1:0] head_word;

  assign in_fire = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_OP;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: header, operand, then wait for FIFO room
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OP:    if (in_fire) state_next = S_OPND;
      S_OPND:  if (in_fire) state_next = S_EXEC;
      S_EXEC:  if (!fifo_full) state_next = S_OP;
      default: state_next = S_OP;
    endcase
  end

  // FSM outputs depend on state (and FIFO room for the push) only
  always_comb begin
    in_ready  = 1'b0;
    fifo_push = 1'b0;
    case (state_reg)
      S_OP, S_OPND: in_ready = 1'b1;
      S_EXEC:       fifo_push = !fifo_full;
      default:      in_ready = 1'b0;
    endcase
  end

  // Header latch and ALU operand registers; ALU inputs move only on byte 1
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_op_reg <= '0;
      alu_op_reg <= '0;
      alu_a_reg  <= '0;
      alu_b_reg  <= '0;
    end else if (in_fire) begin
      if (state_reg == S_OP) begin
        hdr_op_reg <= in_data[7:4];
      end else if (state_reg == S_OPND) begin
        alu_op_reg <= hdr_op_reg;
        alu_a_reg  <= in_data[7:4];
        alu_b_reg  <= in_data[3:0];
      end
    end
  end

  // Build the FIFO entry from the ALU result and the opcode filter
  always_comb begin
    push_word = {1'b0, alu_result};
    if (op_is_undefined(alu_op_reg)) begin
      push_word = {1'b1, 8'h00};
    end
`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    else if (alu_op_reg == OP_DIV && alu_b_reg == 4'd0) begin
      push_word = {1'b1, 8'hFF};
    end
`endif
  end

  alu_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (out_ready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign out_data  = head_word[7:0];
  assign out_err   = head_word[8];
  assign out_valid = !fifo_empty;
  assign busy      = (state_reg != S_OP) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a
// behavioural 4-bit ALU closing the loop. Inputs change and outputs are
// sampled on the falling edge.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_result;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // Stand-in ALU; undefined opcodes and divide-by-zero return marker values
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      4'd0:  return ea + eb;
      4'd1:  return ea - eb;
      4'd2:  return ea * eb;
      4'd3:  return (b == 4'd0) ? 8'hA5 : ea / eb;
      4'd4:  return ea & eb;
      4'd5:  return ea | eb;
      4'd6:  return {4'b0, ~a};
      4'd7:  return {4'b0, ~b};
      4'd8:  return ea * ea;
      4'd9:  return eb * eb;
      4'd10: return {7'b0, a < b};
      4'd11: return {7'b0, a == b};
      4'd12: return {7'b0, a > b};
      default: return 8'hEE;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte from a falling edge and hold it until it transfers
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("send byte %02h", b);
  endtask

  // Wait for a result, check it, then pop it
  task automatic pop_expect(input string tag, input logic [7:0] d, input logic e);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    $display("pop %s data %02h err %0d", tag, out_data, out_err);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu", {20'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Add 3+5 with exact latency: S_EXEC next cycle, result the one after
    send_byte(8'h00);
    send_byte(8'h35);
    @(negedge clk);
    chk("add_exec_in_ready", 32'(in_ready), 32'd0);
    chk("add_alu", {20'd0, alu_op, alu_a, alu_b}, 32'h035);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("add_valid_n2", 32'(out_valid), 32'd1);
    pop_expect("add", 8'h08, 1'b0);

    // Subtract then divide, results in order
    send_byte(8'h10);
    send_byte(8'h35);
    send_byte(8'h30);
    send_byte(8'h92);
    pop_expect("sub", 8'hFE, 1'b0);
    pop_expect("div", 8'h04, 1'b0);

    // Undefined opcode 13
    send_byte(8'hD0);
    send_byte(8'h11);
    pop_expect("inv", 8'h00, 1'b1);

    // Divide by zero
    send_byte(8'h30);
    send_byte(8'h70);
`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    pop_expect("div0", 8'hFF, 1'b1);
`else
    pop_expect("div0", 8'hA5, 1'b0);
`endif
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Backpressure: four fill the FIFO, the fifth waits in S_EXEC
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'h00);
      send_byte({i[3:0], i[3:0]});
    end
    repeat (3) @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_alu", {20'd0, alu_op, alu_a, alu_b}, 32'h055);
    chk("bp_head", 32'(out_data), 32'h02);
    repeat (4) @(negedge clk);
    chk("bp_alu_hold", {20'd0, alu_op, alu_a, alu_b}, 32'h055);
    chk("bp_busy", 32'(busy), 32'd1);
    pop_expect("bp1", 8'h02, 1'b0);
    pop_expect("bp2", 8'h04, 1'b0);
    pop_expect("bp3", 8'h06, 1'b0);
    pop_expect("bp4", 8'h08, 1'b0);
    pop_expect("bp5", 8'h0A, 1'b0);
    repeat (2) @(negedge clk);
    chk("bp_done_busy", 32'(busy), 32'd0);
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // Reset between header and operand byte discards the header
    send_byte(8'h20);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_alu", {20'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", {23'd0, out_valid, out_err, out_data}, 32'd0);
    rst = 1'b0;
    send_byte(8'h00);
    send_byte(8'h23);
    pop_expect("mid", 8'h05, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_single", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream front-end for the 4-bit combinational ALU (`tt_um_ALU_4bit`). It accepts a two-byte command stream over a valid/ready byte interface and decodes each command into opcode plus A/B operands. It drives registered operands into the ALU and captures the 8-bit result into a small result FIFO, tagging each result with an error flag. This stabilises the ALU's inputs, filters the opcodes the ALU leaves undefined, and decouples the producer from the result consumer.

## Interface
- Clock: one clock. Reset: synchronous, active-high.
- `FIFO_DEPTH`, default 4: result FIFO entries; must be a power of two, minimum 2.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous active-high reset.
- `in_data`  in  8  command byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  sequencer accepts a byte this cycle.
- `alu_op`  out  4  registered opcode to the ALU `ena`.
- `alu_a`  out  4  registered operand to the ALU `ui_in`.
- `alu_b`  out  4  registered operand to the ALU `uio_in`.
- `alu_result`  in  8  ALU `uo_out`; combinational from `alu_op`/`alu_a`/`alu_b`.
- `out_data`  out  8  FIFO head result.
- `out_err`  out  1  FIFO head error flag.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer pops the head this cycle.
- `busy`  out  1  FSM not in `S_OP`, or FIFO non-empty.

## Operation
- A byte transfers when `in_valid && in_ready`.
- Byte 0 is the header: `[7:4]` = opcode, `[3:0]` ignored.
- Byte 1 is the operand byte: `[7:4]` = A, `[3:0]` = B.
- **`S_OP`:** `in_ready=1`. On transfer, latch the opcode and go to `S_OPND`.
- **`S_OPND`:** `in_ready=1`. On transfer, load `alu_op`/`alu_a`/`alu_b` and go to `S_EXEC`.
- **`S_EXEC`:** `in_ready=0`.
  - If the FIFO is not full, push `{err, data}` and go to `S_OP`.
  - If the FIFO is full, stay in `S_EXEC`; ALU inputs are held stable.
- Push contents by opcode:
  - Opcodes 0–12: `data = alu_result`, `err = 0`.
  - Opcodes 13–15: `data = 8'h00`, `err = 1`. `alu_result` is ignored because the ALU does not define these opcodes.
- `alu_*` change only on a byte-1 transfer or on reset.
- FIFO:
  - 9 bits wide, first-in first-out.
  - Pop on `out_valid && out_ready`.
  - Push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`; occupancy counter is `clog2(FIFO_DEPTH)+1` bits.
- **Reset values:** FSM = `S_OP`, `in_ready=1`, `alu_op/alu_a/alu_b = 0`, FIFO empty, `out_valid=0`, `out_data=0`, `out_err=0`, `busy=0`.
- **Reset mid-command:** a latched header is discarded; the next accepted byte is treated as a header. FIFO contents are lost.

## Timing
- Byte-1 transfer at edge N → `alu_*` valid after edge N, FSM in `S_EXEC` during cycle N+1.
- Push at edge N+1 → `out_valid=1` during cycle N+2 (when the FIFO was empty).
- Sustained throughput: one command per 3 cycles with `in_valid` held high and no backpressure.
- `out_data`/`out_err` show the FIFO head combinationally from registered storage; no output register stage.
- `in_ready` depends only on FSM state, never combinationally on `in_valid` or `out_ready`.

## Configuration
- Macro: `ALU_SEQ_DIVZERO_GUARD_EN`.
- **Defined:** opcode 3 (divide) with B = 0 pushes `data = 8'hFF`, `err = 1`.
- **Undefined:** opcode 3 with B = 0 pushes `alu_result` unmodified, `err = 0`.
- All other behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg`, also used by ALU benches, holds:
  - 4-bit opcode localparams `OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_NOTA=6, OP_NOTB=7, OP_SQA=8, OP_SQB=9, OP_LT=10, OP_EQ=11, OP_GT=12`.
  - `OP_LAST=12`.
  - FSM state enum `S_OP/S_OPND/S_EXEC`.
- Sub-module `alu_result_fifo`: synchronous FIFO, parameters width and depth, same clock and reset, ports push/pop/full/empty.

## Test plan
- **Add:** bytes `0x00, 0x35` → after 2 cycles `out_valid=1`, `out_data=0x08`, `out_err=0`.
- **Subtract and divide:** `0x10, 0x35` → `0xFE`, `err=0`. Then `0x30, 0x92` → `0x04`, `err=0`. Results appear in order.
- **Invalid opcode:** `0xD0, 0x11` → `out_data=0x00`, `out_err=1`.
- **Divide by zero:** `0x30, 0x70`.
  - Macro defined → `0xFF`, `err=1`.
  - Macro undefined → `err=0`, `out_data` equals the ALU's value.
- **Backpressure:** `out_ready=0`, five add commands `0x00, 0x11` … `0x00, 0x55`.
  - Four entries fill the FIFO; the fifth holds in `S_EXEC` with `in_ready=0` and stable `alu_*`.
  - Raise `out_ready` → `0x02, 0x04, 0x06, 0x08, 0x0A` in order, then `busy=0`.
- **Reset mid-command:** header `0x20` accepted, assert `rst` for one cycle, then send `0x00, 0x23` → single result `0x05`; all outputs are at reset values during reset.
